// File: rtl/tcam_pkg.sv
// Shared types and helpers for the pipelined ternary CAM.
package tcam_pkg;

    // Largest table the multi-hit helper is sized for; smaller tables zero-extend.
    localparam int TCAM_MAX_DEPTH = 1024;

    // Table update opcode carried on wOp.
    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_INVAL = 1'b1
    } tcam_op_e;

    // True when at least two bits of vec are set: a running "first hit seen"
    // flag ORed with "another hit after it", with no full population count.
    function automatic logic popcount_ge2(input logic [TCAM_MAX_DEPTH-1:0] vec);
        logic seen;
        logic second;
        seen   = 1'b0;
        second = 1'b0;
        for (int i = 0; i < TCAM_MAX_DEPTH; i++) begin
            second = second | (seen & vec[i]);
            seen   = seen | vec[i];
        end
        return second;
    endfunction

endpackage

// File: rtl/tcam_pe.sv
// Lowest-index-wins priority encoder over a hit vector, with any/multi flags.
// Purely combinational; DEPTH must not exceed TCAM_MAX_DEPTH.
module tcam_pe
    import tcam_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] hits,
    output logic [AW-1:0]    addr,
    output logic             any,
    output logic             multi
);

    logic [TCAM_MAX_DEPTH-1:0] hits_ext;

    // Scan from the top down so the lowest set index is the last one assigned.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise the missing branch infers a latch.
        hits_ext               = '0;
        hits_ext[DEPTH-1:0]    = hits;
        addr                   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hits[i]) begin
                addr = AW'(i);
            end
        end
        any   = |hits;
        multi = popcount_ge2(hits_ext);
    end

endmodule

// File: rtl/pl_tcam.sv
// Pipelined flip-flop ternary CAM: per-entry pattern/mask/valid storage,
// two-stage lookup (hit vector, then priority encode) with valid/ready
// backpressure, entry invalidation and an occupancy counter.
module pl_tcam
    import tcam_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 36,
    parameter int AW    = $clog2(DEPTH)  // derived, do not override
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wEn,
    input  logic             wOp,
    input  logic [AW-1:0]    wAddr,
    input  logic [WIDTH-1:0] wPatt,
    input  logic [WIDTH-1:0] wMask,
    input  logic             lk_valid,
    output logic             lk_ready,
    input  logic [WIDTH-1:0] lk_key,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             match,
    output logic [AW-1:0]    mAddr,
    output logic             multi,
    output logic [AW:0]      valid_cnt
);

    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] patt [DEPTH];
    logic [WIDTH-1:0] mask [DEPTH];
    logic [DEPTH-1:0] valid;

    tcam_op_e         op;
    logic [DEPTH-1:0] hit_vec;
    logic             stall;

    logic             s1_valid;
    logic [DEPTH-1:0] s1_hits;

    logic [AW-1:0]    pe_addr;
    logic             pe_any;
    logic             pe_multi;

    assign op = tcam_op_e'(wOp);

    // Backpressure only comes from an unconsumed result; lk_valid is not involved.
    assign stall    = res_valid & ~res_ready;
    assign lk_ready = ~stall;

    // Table write decoder: WRITE loads pattern/mask and sets valid, INVAL clears valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage array is reset here only because the table must read back as all-zero after reset; a plain RAM would be left unreset.
            for (int i = 0; i < DEPTH; i++) begin
                patt[i] <= '0;
                mask[i] <= '0;
            end
            valid <= '0;
        end else if (wEn) begin
            if (op == OP_WRITE) begin
                // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
                patt[wAddr]  <= wPatt;
                mask[wAddr]  <= wMask;
                valid[wAddr] <= 1'b1;
            end else begin
                valid[wAddr] <= 1'b0;
            end
        end
    end

    // Occupancy: count only real valid-bit transitions, so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_cnt <= '0;
        end else if (wEn) begin
            if (op == OP_WRITE && !valid[wAddr]) begin
                valid_cnt <= valid_cnt + CNT_ONE;
            end else if (op == OP_INVAL && valid[wAddr]) begin
                valid_cnt <= valid_cnt - CNT_ONE;
            end
        end
    end

    // Ternary compare of the incoming key against the pre-edge table contents.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = valid[i] & ~|((lk_key ^ patt[i]) & ~mask[i]);
        end
    end

    // S1: capture the hit vector of an accepted key; holds during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_hits  <= '0;
        end else if (!stall) begin
            s1_valid <= lk_valid;
            if (lk_valid) begin
                s1_hits <= hit_vec;
            end
        end
    end

    tcam_pe #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_pe (
        .hits  (s1_hits),
        .addr  (pe_addr),
        .any   (pe_any),
        .multi (pe_multi)
    );

    // S2: register the encoded result; outputs stay frozen while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            match     <= 1'b0;
            mAddr     <= '0;
            multi     <= 1'b0;
        end else if (!stall) begin
            res_valid <= s1_valid;
            if (s1_valid) begin
                match <= pe_any;
                mAddr <= pe_addr;
                multi <= pe_multi;
            end
        end
    end

endmodule

// File: tb/tb_pl_tcam.sv
// Scoreboard bench for pl_tcam: the driver pushes hand-computed expected
// results as keys are issued; a monitor pops and compares on each handshake.
module tb_pl_tcam;

    localparam int DEPTH = 64;
    localparam int WIDTH = 36;
    localparam int AW    = 6;

    typedef struct packed {
        logic          m;
        logic [AW-1:0] a;
        logic          mu;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             wEn;
    logic             wOp;
    logic [AW-1:0]    wAddr;
    logic [WIDTH-1:0] wPatt;
    logic [WIDTH-1:0] wMask;
    logic             lk_valid;
    logic             lk_ready;
    logic [WIDTH-1:0] lk_key;
    logic             res_valid;
    logic             res_ready;
    logic             match;
    logic [AW-1:0]    mAddr;
    logic             multi;
    logic [AW:0]      valid_cnt;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_results = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    pl_tcam #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wEn       (wEn),
        .wOp       (wOp),
        .wAddr     (wAddr),
        .wPatt     (wPatt),
        .wMask     (wMask),
        .lk_valid  (lk_valid),
        .lk_ready  (lk_ready),
        .lk_key    (lk_key),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .match     (match),
        .mAddr     (mAddr),
        .multi     (multi),
        .valid_cnt (valid_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one pop per accepted result.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got addr 0x%0h expected no result", mAddr);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_match", match, mon_e.m);
                check("res_addr",  mAddr, mon_e.a);
                check("res_multi", multi, mon_e.mu);
                n_results++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int addr, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] m);
        wEn = 1'b1; wOp = 1'b0; wAddr = AW'(addr); wPatt = p; wMask = m;
        tick();
        wEn = 1'b0;
    endtask

    task automatic do_inval(input int addr);
        wEn = 1'b1; wOp = 1'b1; wAddr = AW'(addr);
        tick();
        wEn = 1'b0;
    endtask

    task automatic lookup(input logic [WIDTH-1:0] key, input exp_t e);
        logic accepted;
        accepted = 1'b0;
        lk_valid = 1'b1;
        lk_key   = key;
        exp_q.push_back(e);
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            if (lk_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        lk_valid = 1'b0;
        check("lk_accept", accepted, 1'b1);
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    logic [WIDTH-1:0] s_keys [8];
    exp_t             s_exps [8];

    initial begin
        rst = 1'b1; wEn = 1'b0; wOp = 1'b0; wAddr = '0; wPatt = '0; wMask = '0;
        lk_valid = 1'b0; lk_key = '0; res_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_res_valid", res_valid, 0);
        check("rst_match", match, 0);
        check("rst_addr", mAddr, 0);
        check("rst_multi", multi, 0);
        check("rst_cnt", valid_cnt, 0);
        check("rst_lk_ready", lk_ready, 1);
        tick();

        // Basic masked hit and latency
        do_write(5, 36'h0000000AB, 36'hFFFFFFF00);
        lookup(36'h1234567AB, '{m: 1'b1, a: 6'd5, mu: 1'b0});
        check("lat_s1_only", res_valid, 0);
        tick();
        check("lat_result", res_valid, 1);
        drain();
        check("cnt_one", valid_cnt, 1);

        // Multi-hit, then invalidate the lower entry
        do_write(3, 36'h000000000, 36'hFFFFFFFFF);
        do_write(9, 36'h000000000, 36'hFFFFFFFFF);
        lookup(36'h000000ABC, '{m: 1'b1, a: 6'd3, mu: 1'b1});
        drain();
        check("cnt_three", valid_cnt, 3);
        do_inval(3);
        lookup(36'h000000ABC, '{m: 1'b1, a: 6'd9, mu: 1'b0});
        drain();
        check("cnt_after_inval", valid_cnt, 2);
        do_inval(9);

        // Write/lookup hazard: same cycle sees old contents, next cycle sees new
        wEn = 1'b1; wOp = 1'b0; wAddr = 6'd7; wPatt = 36'h000000001; wMask = '0;
        lookup(36'h000000001, '{m: 1'b0, a: 6'd0, mu: 1'b0});
        wEn = 1'b0;
        lookup(36'h000000001, '{m: 1'b1, a: 6'd7, mu: 1'b0});
        drain();
        check("cnt_hazard", valid_cnt, 2);

        // Stream of 8 keys with a 4-cycle stall on the first result
        do_write(2,  36'h0000000A0, 36'h00000000F);
        do_write(12, 36'h0000000AB, 36'h000000000);
        check("cnt_stream", valid_cnt, 4);
        s_keys[0] = 36'h000000001; s_exps[0] = '{m: 1'b1, a: 6'd7,  mu: 1'b0};
        s_keys[1] = 36'h0000000AB; s_exps[1] = '{m: 1'b1, a: 6'd2,  mu: 1'b1};
        s_keys[2] = 36'hF000000AB; s_exps[2] = '{m: 1'b1, a: 6'd5,  mu: 1'b0};
        s_keys[3] = 36'h0000000A3; s_exps[3] = '{m: 1'b1, a: 6'd2,  mu: 1'b0};
        s_keys[4] = 36'h000000002; s_exps[4] = '{m: 1'b0, a: 6'd0,  mu: 1'b0};
        s_keys[5] = 36'h5555555AB; s_exps[5] = '{m: 1'b1, a: 6'd5,  mu: 1'b0};
        s_keys[6] = 36'h0000000AF; s_exps[6] = '{m: 1'b1, a: 6'd2,  mu: 1'b0};
        s_keys[7] = 36'h000000001; s_exps[7] = '{m: 1'b1, a: 6'd7,  mu: 1'b0};
        n_results = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) lookup(s_keys[i], s_exps[i]);
            end
            begin
                logic seen;
                seen = 1'b0;
                for (int c = 0; c < 50 && !seen; c++) begin
                    @(posedge clk);
                    #1;
                    if (res_valid) seen = 1'b1;
                end
                check("stall_first_seen", seen, 1);
                res_ready = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check("stall_lk_ready", lk_ready, 0);
                    check("stall_res_valid", res_valid, 1);
                    check("stall_hold_match", match, 1);
                    check("stall_hold_addr", mAddr, 7);
                    @(posedge clk);
                    #1;
                end
                res_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", n_results, 8);

        // Fill the table, re-write, double invalidate
        for (int i = 0; i < DEPTH; i++) do_write(i, WIDTH'(i), '0);
        check("cnt_full", valid_cnt, 64);
        lookup(36'h00000003F, '{m: 1'b1, a: 6'd63, mu: 1'b0});
        drain();
        do_write(0, '0, '0);
        check("cnt_rewrite", valid_cnt, 64);
        do_inval(0);
        check("cnt_inval1", valid_cnt, 63);
        do_inval(0);
        check("cnt_inval2", valid_cnt, 63);

        // Reset with two lookups in flight, and a write coincident with reset
        res_ready = 1'b0;
        lookup(36'h000000005, '{m: 1'b1, a: 6'd5, mu: 1'b0});
        lookup(36'h000000006, '{m: 1'b1, a: 6'd6, mu: 1'b0});
        #2;
        rst = 1'b1;
        exp_q.delete();
        wEn = 1'b1; wOp = 1'b0; wAddr = 6'd0; wPatt = '0; wMask = '0;
        tick();
        rst = 1'b0;
        wEn = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_res_valid", res_valid, 0);
            check("post_rst_cnt", valid_cnt, 0);
            check("post_rst_lk_ready", lk_ready, 1);
            @(posedge clk);
            #1;
        end
        lookup(36'h000000000, '{m: 1'b0, a: 6'd0, mu: 1'b0});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
